// File: rtl/sum_accumulator_if.sv
// TL_UL_8_32_8_32: TileLink-UL link with 8-bit source/sink IDs, 32-bit
// address and 32-bit data.
//
// Handshake: a beat moves on the A channel when a_valid && a_ready are both
// high at a rising clk edge. A beat moves on the D channel when
// d_valid && d_ready are both high at a rising clk edge. A sender that has
// raised valid holds the payload stable until the beat moves, and never
// waits for ready before raising valid.
//
// Modports:
//   requester - drives the A channel and d_ready
//   responder - drives the D channel and a_ready
interface TL_UL_8_32_8_32;
    // A channel: request
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;

    // D channel: response
    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [7:0]  d_sink;
    logic [31:0] d_data;
    logic        d_error;

    modport requester (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        output d_ready
    );

    modport responder (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        input  d_ready
    );
endinterface

// File: rtl/sum_accumulator.sv
// sum_accumulator: saturating signed accumulator of the adder pipeline's sum,
// with a 16-bit saturating sample counter. Software control and status go
// through a TL-UL register responder.
//
// Ports:
//   clk        - clock, all state changes on its rising edge
//   rst_b      - asynchronous active-low reset
//   sum_valid  - sum carries a new sample this cycle
//   sum        - signed sample, SUM_WIDTH bits
//   regs       - TL-UL responder (register access)
//   dbg_state  - handshake FSM state (0 = IDLE, 1 = RESP)
//
// Register map (word addresses):
//   0x0 CTRL   RW   bit0 enable, bit1 clear (self-clearing, reads 0)
//   0x4 ACC    RO   accumulator, sign-extended to 32 bits
//   0x8 COUNT  RO   sample count in [15:0], saturates at 0xFFFF
//   0xC STATUS W1C  bit0 sat_hi, bit1 sat_lo (sticky)
module sum_accumulator #(
    parameter int SUM_WIDTH = 10,
    parameter int ACC_WIDTH = 24   // valid range 11..32
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 sum_valid,
    input  logic [SUM_WIDTH-1:0] sum,
    TL_UL_8_32_8_32.responder    regs,
    output logic                 dbg_state
);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

    state_t state_q, state_d;

    logic [ACC_WIDTH-1:0] acc_q;
    logic [15:0]          count_q;
    logic [1:0]           status_q;
    logic                 enable_q;

    logic [2:0]  d_opcode_q;
    logic [1:0]  d_size_q;
    logic [7:0]  d_source_q;
    logic [31:0] d_data_q;
    logic        d_error_q;

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    logic accept;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (regs.a_valid) begin
                    accept  = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (regs.d_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // a_ready/d_valid are pure decodes of the state flop, so no a_* input
    // reaches the D channel combinationally.
    assign regs.a_ready = (state_q == S_IDLE);
    assign regs.d_valid = (state_q == S_RESP);
    assign dbg_state    = (state_q == S_RESP);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        is_get;
    logic        is_put;
    logic        req_err;
    logic [1:0]  reg_idx;
    logic        ctrl_wr;
    logic        clear_req;
    logic [1:0]  status_w1c;
    logic [31:0] rd_data;
    logic [31:0] acc_ext;

    assign is_get  = (regs.a_opcode == OP_GET);
    assign is_put  = (regs.a_opcode == OP_PUT_FULL) || (regs.a_opcode == OP_PUT_PART);
    assign req_err = (regs.a_address[1:0] != 2'b00) ||
                     (regs.a_address >= 32'h10) ||
                     !(is_get || is_put);
    assign reg_idx = regs.a_address[3:2];

    // Only byte 0 of CTRL and STATUS holds anything; a cleared mask[0]
    // makes the write a no-op.
    assign ctrl_wr    = accept && is_put && !req_err && (reg_idx == 2'd0) && regs.a_mask[0];
    assign clear_req  = ctrl_wr && regs.a_data[1];
    assign status_w1c = (accept && is_put && !req_err && (reg_idx == 2'd3) && regs.a_mask[0])
                        ? regs.a_data[1:0] : 2'b00;

    // ACC_WIDTH <= 32 guarantees at least one copy of the sign bit here.
    assign acc_ext = {{(33 - ACC_WIDTH){acc_q[ACC_WIDTH-1]}}, acc_q[ACC_WIDTH-2:0]};

    always_comb begin
        rd_data = 32'd0;
        case (reg_idx)
            2'd0: rd_data = {31'd0, enable_q};
            2'd1: rd_data = acc_ext;
            2'd2: rd_data = {16'd0, count_q};
            2'd3: rd_data = {30'd0, status_q};
            default: rd_data = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Response registers: captured at the acceptance edge, held in RESP
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            d_opcode_q <= 3'd0;
            d_size_q   <= 2'd0;
            d_source_q <= 8'd0;
            d_data_q   <= 32'd0;
            d_error_q  <= 1'b0;
        end else if (accept) begin
            d_opcode_q <= is_get ? OP_ACK_DATA : OP_ACK;
            d_size_q   <= regs.a_size;
            d_source_q <= regs.a_source;
            d_data_q   <= (is_get && !req_err) ? rd_data : 32'd0;
            d_error_q  <= req_err;
        end
    end

    assign regs.d_opcode = d_opcode_q;
    assign regs.d_param  = 3'd0;
    assign regs.d_size   = d_size_q;
    assign regs.d_source = d_source_q;
    assign regs.d_sink   = 8'd0;
    assign regs.d_data   = d_data_q;
    assign regs.d_error  = d_error_q;

    // ------------------------------------------------------------------
    // Saturating accumulator
    // ------------------------------------------------------------------
    // One guard bit above ACC_WIDTH: the two top bits disagree exactly when
    // the true sum is outside the representable range.
    logic [ACC_WIDTH:0]   sum_wide;
    logic [ACC_WIDTH:0]   acc_wide;
    logic [ACC_WIDTH-1:0] acc_next;
    logic [1:0]           sat_set;
    logic                 take;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    assign take     = sum_valid && enable_q;
    assign sum_wide = {{(ACC_WIDTH + 1 - SUM_WIDTH){sum[SUM_WIDTH-1]}}, sum};
    assign acc_wide = {acc_q[ACC_WIDTH-1], acc_q} + sum_wide;

    always_comb begin
        acc_next = acc_wide[ACC_WIDTH-1:0];
        sat_set  = 2'b00;
        if (acc_wide[ACC_WIDTH] != acc_wide[ACC_WIDTH-1]) begin
            if (acc_wide[ACC_WIDTH]) begin
                acc_next = ACC_MIN;
                sat_set  = 2'b10;
            end else begin
                acc_next = ACC_MAX;
                sat_set  = 2'b01;
            end
        end
    end

    // Clear beats a same-cycle sample; a new saturation beats a same-cycle
    // W1C of the same bit. enable is sampled from its flop, so a CTRL write
    // governs samples from the following cycle on.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            acc_q    <= '0;
            count_q  <= 16'd0;
            status_q <= 2'b00;
            enable_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable_q <= regs.a_data[0];
            end
            if (clear_req) begin
                acc_q    <= '0;
                count_q  <= 16'd0;
                status_q <= 2'b00;
            end else if (take) begin
                acc_q    <= acc_next;
                count_q  <= (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                status_q <= (status_q & ~status_w1c) | sat_set;
            end else begin
                status_q <= status_q & ~status_w1c;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{regs.a_param, regs.a_data[31:2], regs.a_mask[3:1]};

endmodule

// File: tb/tb_sum_accumulator.sv
module tb_sum_accumulator;

    localparam int SW = 10;
    localparam int AW = 11;

    logic          clk;
    logic          rst_b;
    logic          sum_valid;
    logic [SW-1:0] sum;
    logic          dbg_state;

    TL_UL_8_32_8_32 regs_if ();

    sum_accumulator #(.SUM_WIDTH(SW), .ACC_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .sum_valid (sum_valid),
        .sum       (sum),
        .regs      (regs_if),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // ---------------- driver tasks ----------------
    // All drivers start and end just after a falling edge.
    task automatic feed(input int v);
        sum_valid = 1'b1;
        sum       = SW'(v);
        @(posedge clk);
        @(negedge clk);
        sum_valid = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] mask,
                         input logic [31:0] data, input logic [7:0] src);
        regs_if.a_valid   = 1'b1;
        regs_if.a_opcode  = op;
        regs_if.a_param   = 3'd0;
        regs_if.a_size    = 2'd2;
        regs_if.a_source  = src;
        regs_if.a_address = addr;
        regs_if.a_mask    = mask;
        regs_if.a_data    = data;
    endtask

    // Wait for a_ready, let the acceptance edge pass, drop a_valid and any
    // sample that was lined up with the request.
    task automatic wait_accept(input string name);
        int n = 0;
        while (!regs_if.a_ready && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!regs_if.a_ready) timeout_fail({name, "_accept"});
        @(posedge clk);
        @(negedge clk);
        regs_if.a_valid = 1'b0;
        sum_valid       = 1'b0;
    endtask

    task automatic wait_resp(input string name, input logic [7:0] src,
                             output logic [31:0] rdata, output logic err, output logic [2:0] dop);
        int n = 0;
        while (!regs_if.d_valid && n < 20) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!regs_if.d_valid) timeout_fail({name, "_resp"});
        rdata = regs_if.d_data;
        err   = regs_if.d_error;
        dop   = regs_if.d_opcode;
        check({name, "_src"}, {24'd0, regs_if.d_source}, {24'd0, src});
        check({name, "_size"}, {30'd0, regs_if.d_size}, 32'd2);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tl_txn(input string name, input logic [2:0] op, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] data, input logic [7:0] src,
                          output logic [31:0] rdata, output logic err, output logic [2:0] dop);
        issue(op, addr, mask, data, src);
        wait_accept(name);
        wait_resp(name, src, rdata, err, dop);
    endtask

    task automatic read_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        er;
        logic [2:0]  op;
        tl_txn(name, 3'd4, addr, 4'hF, 32'd0, 8'hA5, rd, er, op);
        check({name, "_err"}, {31'd0, er}, 32'd0);
        check(name, rd, exp);
    endtask

    task automatic write_reg(input string name, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic        er;
        logic [2:0]  op;
        tl_txn(name, 3'd0, addr, 4'hF, data, 8'h3C, rd, er, op);
        check({name, "_err"}, {31'd0, er}, 32'd0);
        check({name, "_op"}, {29'd0, op}, 32'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        exp_err;
        logic [2:0]  exp_op;
        logic [31:0] exp_data;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [2:0]  op;

        // Table applied after the first accumulation (ACC=102, COUNT=3, enable=1).
        vecs[0]  = '{3'd4, 32'h0,  4'hF, 32'h0,    1'b0, 3'd1, 32'd102};
        vecs[1]  = '{3'd4, 32'h8,  4'hF, 32'h0,    1'b0, 3'd1, 32'd3};
        vecs[2]  = '{3'd4, 32'hC,  4'hF, 32'h0,    1'b0, 3'd1, 32'd0};
        vecs[3]  = '{3'd4, 32'h0,  4'hF, 32'h0,    1'b0, 3'd1, 32'd1};
        vecs[4]  = '{3'd4, 32'h6,  4'hF, 32'h0,    1'b1, 3'd1, 32'd0};
        vecs[5]  = '{3'd4, 32'h20, 4'hF, 32'h0,    1'b1, 3'd1, 32'd0};
        vecs[6]  = '{3'd2, 32'h0,  4'hF, 32'h2,    1'b1, 3'd0, 32'd0};
        vecs[7]  = '{3'd0, 32'h4,  4'hF, 32'h1234, 1'b0, 3'd0, 32'd0};
        vecs[8]  = '{3'd0, 32'h8,  4'hF, 32'h55,   1'b0, 3'd0, 32'd0};
        vecs[9]  = '{3'd4, 32'h4,  4'hF, 32'h0,    1'b0, 3'd1, 32'd102};
        vecs[10] = '{3'd4, 32'h8,  4'hF, 32'h0,    1'b0, 3'd1, 32'd3};
        vecs[11] = '{3'd1, 32'h0,  4'h0, 32'h0,    1'b0, 3'd0, 32'd0};
        vecs[12] = '{3'd4, 32'h0,  4'hF, 32'h0,    1'b0, 3'd1, 32'd1};
        vecs[13] = '{3'd1, 32'h0,  4'hE, 32'h2,    1'b0, 3'd0, 32'd0};
        vecs[14] = '{3'd4, 32'h0,  4'hF, 32'h0,    1'b0, 3'd1, 32'd1};
        vecs[15] = '{3'd0, 32'h10, 4'hF, 32'h0,    1'b1, 3'd0, 32'd0};
        vecs[16] = '{3'd0, 32'h1,  4'hF, 32'h2,    1'b1, 3'd0, 32'd0};
        vecs[17] = '{3'd4, 32'h0,  4'hF, 32'h0,    1'b0, 3'd1, 32'd1};
        // vec 0 reads CTRL? no: address 0x4 is ACC
        vecs[0].addr = 32'h4;

        // ---------- reset ----------
        rst_b = 1'b0;
        sum_valid = 1'b0;
        sum = '0;
        regs_if.d_ready = 1'b1;
        issue(3'd4, 32'h0, 4'hF, 32'h0, 8'h00);
        regs_if.a_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a_ready", {31'd0, regs_if.a_ready}, 32'd1);
        check("rst_d_valid", {31'd0, regs_if.d_valid}, 32'd0);
        check("rst_d_opcode", {29'd0, regs_if.d_opcode}, 32'd0);
        check("rst_d_error", {31'd0, regs_if.d_error}, 32'd0);
        check("rst_d_data", regs_if.d_data, 32'd0);
        check("rst_d_src_sink", {16'd0, regs_if.d_source, regs_if.d_sink}, 32'd0);
        check("rst_dbg_state", {31'd0, dbg_state}, 32'd0);
        rst_b = 1'b1;
        @(negedge clk);

        // ---------- basic accumulation ----------
        write_reg("ctrl_en", 32'h0, 32'h1);
        feed(5);
        feed(-3);
        feed(100);

        // ---------- table ----------
        for (int i = 0; i < NV; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            tl_txn(nm, vecs[i].op, vecs[i].addr, vecs[i].mask, vecs[i].data,
                   8'(8'h30 + i), rd, er, op);
            check({nm, "_err"}, {31'd0, er}, {31'd0, vecs[i].exp_err});
            check({nm, "_op"}, {29'd0, op}, {29'd0, vecs[i].exp_op});
            check({nm, "_data"}, rd, vecs[i].exp_data);
        end

        // ---------- positive saturation at ACC_WIDTH=11 ----------
        write_reg("ctrl_clr_en", 32'h0, 32'h3);
        read_chk("acc_after_clr", 32'h4, 32'd0);
        for (int i = 0; i < 4; i++) feed(511);
        read_chk("acc_sat_hi", 32'h4, 32'h3FF);
        read_chk("status_sat_hi", 32'hC, 32'd1);
        read_chk("count_4", 32'h8, 32'd4);
        write_reg("status_w1c_hi", 32'hC, 32'h1);
        read_chk("status_after_w1c", 32'hC, 32'd0);
        read_chk("acc_after_w1c", 32'h4, 32'h3FF);

        // ---------- negative saturation ----------
        for (int i = 0; i < 5; i++) feed(-512);
        read_chk("acc_sat_lo", 32'h4, 32'hFFFF_FC00);
        read_chk("status_sat_lo", 32'hC, 32'd2);
        read_chk("count_9", 32'h8, 32'd9);
        tl_txn("status_w1c_nomask", 3'd1, 32'hC, 4'h0, 32'h3, 8'h41, rd, er, op);
        read_chk("status_nomask", 32'hC, 32'd2);

        // W1C of sat_lo on the same edge as a new negative clamp: set wins.
        sum_valid = 1'b1;
        sum = SW'(-512);
        tl_txn("w1c_vs_sat", 3'd0, 32'hC, 4'hF, 32'h2, 8'h42, rd, er, op);
        read_chk("status_set_wins", 32'hC, 32'd2);
        read_chk("count_10", 32'h8, 32'd10);
        write_reg("status_w1c_all", 32'hC, 32'h3);
        read_chk("status_cleared", 32'hC, 32'd0);

        // ---------- clear vs. same-cycle sample ----------
        sum_valid = 1'b1;
        sum = SW'(7);
        tl_txn("clr_vs_sample", 3'd0, 32'h0, 4'hF, 32'h3, 8'h43, rd, er, op);
        read_chk("acc_clr_wins", 32'h4, 32'd0);
        read_chk("count_clr_wins", 32'h8, 32'd0);
        read_chk("ctrl_clear_reads0", 32'h0, 32'd1);

        // ---------- enable write applies from the next sample ----------
        sum_valid = 1'b1;
        sum = SW'(7);
        tl_txn("dis_vs_sample", 3'd0, 32'h0, 4'hF, 32'h0, 8'h44, rd, er, op);
        feed(9);
        read_chk("acc_old_enable", 32'h4, 32'd7);
        read_chk("count_old_enable", 32'h8, 32'd1);
        read_chk("ctrl_disabled", 32'h0, 32'd0);

        // ---------- D-channel backpressure ----------
        regs_if.d_ready = 1'b0;
        issue(3'd4, 32'h4, 4'hF, 32'h0, 8'h77);
        wait_accept("bp");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_d_valid_%0d", i), {31'd0, regs_if.d_valid}, 32'd1);
            check($sformatf("bp_d_data_%0d", i), regs_if.d_data, 32'd7);
            check($sformatf("bp_a_ready_%0d", i), {31'd0, regs_if.a_ready}, 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_src", {24'd0, regs_if.d_source}, 32'h77);
        regs_if.d_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_a_ready_after", {31'd0, regs_if.a_ready}, 32'd1);
        check("bp_d_valid_after", {31'd0, regs_if.d_valid}, 32'd0);

        // ---------- asynchronous reset while in RESP ----------
        write_reg("ctrl_clr_en2", 32'h0, 32'h3);
        feed(50);
        regs_if.d_ready = 1'b0;
        issue(3'd4, 32'h4, 4'hF, 32'h0, 8'h5A);
        wait_accept("rst_mid");
        check("rst_mid_d_valid", {31'd0, regs_if.d_valid}, 32'd1);
        check("rst_mid_d_data", regs_if.d_data, 32'd50);
        #2;
        rst_b = 1'b0;
        #1;
        check("arst_d_valid", {31'd0, regs_if.d_valid}, 32'd0);
        check("arst_a_ready", {31'd0, regs_if.a_ready}, 32'd1);
        check("arst_d_data", regs_if.d_data, 32'd0);
        check("arst_d_fields", {19'd0, regs_if.d_opcode, regs_if.d_error, regs_if.d_source, regs_if.d_size},
              32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        regs_if.d_ready = 1'b1;
        @(negedge clk);
        read_chk("acc_post_rst", 32'h4, 32'd0);
        read_chk("ctrl_post_rst", 32'h0, 32'd0);
        read_chk("count_post_rst", 32'h8, 32'd0);

        // ---------- report ----------
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the pipelined three-input adder's 10-bit signed `sum`. Accumulates each valid sum into a saturating signed accumulator and counts accepted samples. Exposes control, result and status to software through a TL-UL responder port of the same `TL_UL_8_32_8_32` interface type the adders carry. Sits between the adder pipeline and the TL-UL register crossbar.

## Interface
Parameters:
- `SUM_WIDTH`, 10: width of the signed input sum.
- `ACC_WIDTH`, 24: width of the signed accumulator; valid range 11..32.

Ports:
- `clk`  in  1  single clock for the whole block; all state changes on its rising edge.
- `rst_b`  in  1  reset, asynchronous, active-low.
- `sum_valid`  in  1  `sum` carries a new sample this cycle.
- `sum`  in  SUM_WIDTH signed  adder result.
- `regs`  `TL_UL_8_32_8_32.responder`  TL-UL register access, with 8-bit source and sink, 32-bit address and 32-bit data.

## Operation
Register map (word addresses):
- 0x0 CTRL (RW):
  - bit0 `enable`, reset value 0.
  - bit1 `clear`: writing 1 zeroes ACC, COUNT and STATUS. Self-clearing; always reads 0.
- 0x4 ACC (RO): accumulator, sign-extended to 32 bits.
- 0x8 COUNT (RO): 16-bit sample count in bits[15:0], zero-extended; saturates at 0xFFFF.
- 0xC STATUS (W1C):
  - bit0 `sat_hi`: sticky, set when a positive clamp occurs.
  - bit1 `sat_lo`: sticky, set when a negative clamp occurs.

Accumulation, each cycle with `sum_valid && enable`:
- The next value is ACC + sign-extended `sum`.
- If the result is above the maximum, clamp to 2^(ACC_WIDTH-1)-1 and set `sat_hi`.
- If the result is below the minimum, clamp to -2^(ACC_WIDTH-1) and set `sat_lo`.
- COUNT increments by 1 unless it is already 0xFFFF.
- `sum_valid` while `enable` is 0: sample dropped, no state change.

TL-UL protocol:
- Supported opcodes: Get (4), PutFullData (0), PutPartialData (1).
- Responses: AccessAckData (1) for Get; AccessAck (0) for Puts.
- Puts honour `a_mask` per byte. CTRL only uses byte 0. Writes to ACC and COUNT are ignored but still acked with `d_error=0`.
- Error response (`d_error=1`, no state change, read data 0) for any of:
  - address[1:0] != 0;
  - address >= 0x10;
  - any other opcode.
- `d_source` = captured `a_source`; `d_size` = captured `a_size`; `d_sink` = 0.

Handshake FSM:
- IDLE: `a_ready=1`. On `a_valid` the request is accepted, its side effects are performed, and the FSM moves to RESP.
- RESP: `a_ready=0`, `d_valid=1`, and all `d_*` fields stay stable. On `d_ready` the FSM returns to IDLE.
- Only one request is outstanding at a time.

Simultaneous events:
- A CTRL write with `clear=1` in the same cycle as an accepted sample: clear wins. ACC=0, COUNT=0, STATUS=0; the sample is discarded.
- A STATUS W1C in the same cycle as a new saturation: the set wins; the bit stays 1.
- A write to `enable` takes effect on the next cycle's sample.

Reset values:
- ACC=0, COUNT=0, STATUS=0, `enable`=0, FSM=IDLE.
- `a_ready=1`, `d_valid=0`, `d_opcode=0`, `d_error=0`, `d_size=0`, `d_data=0`, `d_source=0`, `d_sink=0`.

## Timing
- Sample latency: `sum_valid` at edge N; ACC/COUNT show the new value after edge N, i.e. readable in cycle N+1.
- TL-UL latency: request accepted at edge N; `d_valid` high in cycle N+1. Read data is sampled at the acceptance edge.
- If `d_ready` is already high in cycle N+1, the next request can be accepted at edge N+2. Maximum throughput is one request per 2 cycles.
- Reset assertion mid-transaction: `d_valid` drops immediately (asynchronous) and the pending response is lost.
- All outputs are registered; there are no combinational paths from `a_*` to `d_*`.

## Test plan
- Reset, write CTRL=1, drive `sum` = 5, -3, 100 on 3 consecutive cycles -> ACC reads 102, COUNT reads 3, STATUS reads 0.
- ACC_WIDTH=11, enable, feed +511 four times -> ACC=1023, `sat_hi`=1. Write STATUS=1 -> `sat_hi`=0, ACC still 1023.
- CTRL write `clear` in the same cycle as `sum_valid` with `sum`=7 -> ACC=0, COUNT=0; CTRL reads back with bit1=0.
- Get at address 0x6, then Get at 0x20 -> both return `d_error=1` with `d_source` echoed. Then opcode 2 -> `d_error=1`, state unchanged.
- Hold `d_ready`=0 for 5 cycles after a Get of ACC -> `d_valid` and `d_data` stay stable and `a_ready` stays 0 throughout. Raise `d_ready` -> `a_ready`=1 on the next cycle.
- Deassert `rst_b` asynchronously while in RESP with ACC=50 -> all outputs at reset values before the next clock edge; ACC reads 0 after reset is released.
